// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM state encoding and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  // Same 3-bit encoding as the transmitter, so state dumps read the same on both ends.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side link bundle: serial line in, parallel word plus status pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must take data_out while valid is high.
interface uart_rx_if #(
  parameter int DATA_BITS = uart_rx_pkg::DATA_BITS_DEF
);

  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  // Pin/consumer side: drives the line and observes the received word.
  modport master (
    output rx,
    input  data_out, valid, frame_err, busy
  );

  // Receiver side.
  modport slave (
    input  rx,
    output data_out, valid, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, parameterised reset value.
// Latency: 2 clk cycles from input change to q_o.
// Backpressure: none.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability filter; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: start-bit detect, mid-bit sampling, LSB-first deserialise, framing check.
// Latency: valid in the cycle after edge 2+H+(DATA_BITS+1)*CLKS_PER_BIT counted from the rx fall.
// Backpressure: none; an unconsumed word is overwritten by the next good frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave rx_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  // Start bit is re-checked half a bit in; data/stop bits are then one full bit apart,
  // which keeps every later sample at mid-bit.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;

  logic                 rx_s;
  logic [CW-1:0]        cnt_d;
  logic [IW-1:0]        idx_d;
  logic [DATA_BITS-1:0] shreg_d;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_if.rx),
    .q_o (rx_s)
  );

  assign cnt_d   = cnt_q + 1'b1;
  assign idx_d   = idx_q + 1'b1;
  assign shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};

  // Frame FSM with bit timer, bit index, shift register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch, silently.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              // Leave at mid-stop so a back-to-back start bit is not missed.
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        BREAK: begin
          // A held-low line reports one framing error, then waits for idle.
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.data_out  = data_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of framed bytes plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  uart_rx_if #(.DATA_BITS(DB)) u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (u_if)
  );

  always #5 clk = ~clk;

  // Cycle counter: value read at a negedge is the number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor.
  int         nvalid = 0;
  int         nferr = 0;
  int         nboth = 0;
  int         nlong = 0;
  int         last_vcyc = 0;
  int         prev_vcyc = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic       valid_prev = 1'b0;
  logic       ferr_prev = 1'b0;
  logic [7:0] rx_log [0:511];

  always @(negedge clk) begin
    if (u_if.valid === 1'b1) begin
      rx_log[nvalid % 512] <= u_if.data_out;
      prev_vcyc <= last_vcyc;
      last_vcyc <= cyc;
      prev_data <= last_data;
      last_data <= u_if.data_out;
      nvalid    <= nvalid + 1;
    end
    if (u_if.frame_err === 1'b1) nferr <= nferr + 1;
    if (u_if.valid === 1'b1 && u_if.frame_err === 1'b1) nboth <= nboth + 1;
    if ((u_if.valid === 1'b1 && valid_prev) || (u_if.frame_err === 1'b1 && ferr_prev)) nlong <= nlong + 1;
    valid_prev <= (u_if.valid === 1'b1);
    ferr_prev  <= (u_if.frame_err === 1'b1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      u_if.rx = 1'b1;
    end
  endtask

  // Drives one frame; returns the cycle count just before the edge that sees the start bit.
  // Ends one cycle short of a full stop bit so a following call is exactly back-to-back.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, output int t0);
    @(negedge clk);
    u_if.rx = 1'b0;
    t0 = cyc;
    for (int i = 0; i < DB; i++) begin
      repeat (CPB) @(negedge clk);
      u_if.rx = d[i];
    end
    repeat (CPB) @(negedge clk);
    u_if.rx = stop_b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop_b;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int t0, t1, bv, bf;
    logic [9:0] frm;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

    // Reset with idle line.
    u_if.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(100);
    check("reset_busy", int'(u_if.busy), 0);
    check("reset_valid", int'(u_if.valid), 0);
    check("reset_frame_err", int'(u_if.frame_err), 0);
    check("reset_data_out", int'(u_if.data_out), 0);

    // Table of single frames separated by idle.
    for (int v = 0; v < 6; v++) begin
      bv = nvalid;
      bf = nferr;
      send_frame(vecs[v].dat, vecs[v].stop_b, t0);
      idle(40);
      check($sformatf("vec%0d_valid_count", v), nvalid - bv, vecs[v].exp_valid);
      check($sformatf("vec%0d_ferr_count", v), nferr - bf, vecs[v].exp_ferr);
      check($sformatf("vec%0d_data_out", v), int'(u_if.data_out), int'(vecs[v].exp_dout));
      if (vecs[v].exp_valid == 1)
        check($sformatf("vec%0d_latency", v), last_vcyc - t0, 155);
    end

    // Back-to-back 0x00 then 0xFF with no idle gap.
    bv = nvalid;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    idle(40);
    check("b2b_valid_count", nvalid - bv, 2);
    check("b2b_first_data", int'(prev_data), 8'h00);
    check("b2b_second_data", int'(last_data), 8'hFF);
    check("b2b_spacing", last_vcyc - prev_vcyc, 160);
    check("b2b_first_latency", prev_vcyc - t0, 155);

    // Short glitch: busy pulses, nothing reported.
    bv = nvalid;
    bf = nferr;
    @(negedge clk);
    u_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", int'(u_if.busy), 1);
    @(negedge clk);
    u_if.rx = 1'b1;
    idle(40);
    check("glitch_busy_low", int'(u_if.busy), 0);
    check("glitch_no_valid", nvalid - bv, 0);
    check("glitch_no_ferr", nferr - bf, 0);

    // Bad stop bit followed by a long break.
    bv = nvalid;
    bf = nferr;
    send_frame(8'h3C, 1'b0, t0);
    repeat (400) @(negedge clk);
    check("break_one_ferr", nferr - bf, 1);
    check("break_no_valid", nvalid - bv, 0);
    check("break_busy_held", int'(u_if.busy), 1);
    check("break_data_kept", int'(u_if.data_out), 8'hFF);
    idle(10);
    check("break_busy_release", int'(u_if.busy), 0);
    check("break_still_one_ferr", nferr - bf, 1);

    // Reset in the middle of a 0x55 frame, then a clean 0x12.
    bv = nvalid;
    bf = nferr;
    frm = {1'b1, 8'h55, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 80; i++) begin
      u_if.rx = frm[i / CPB];
      @(negedge clk);
    end
    check("midrst_busy_before", int'(u_if.busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(u_if.busy), 0);
    check("midrst_valid", int'(u_if.valid), 0);
    check("midrst_ferr", int'(u_if.frame_err), 0);
    check("midrst_data_out", int'(u_if.data_out), 0);
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(200);
    check("midrst_no_valid", nvalid - bv, 0);
    check("midrst_no_ferr", nferr - bf, 0);
    send_frame(8'h12, 1'b1, t0);
    idle(40);
    check("post_rst_valid", nvalid - bv, 1);
    check("post_rst_data", int'(u_if.data_out), 8'h12);
    check("post_rst_latency", last_vcyc - t0, 155);

    // All byte values, back-to-back.
    bv = nvalid;
    bf = nferr;
    for (int b = 0; b < 256; b++) begin
      send_frame(8'(b), 1'b1, t0);
    end
    idle(40);
    check("loop_valid_count", nvalid - bv, 256);
    check("loop_ferr_count", nferr - bf, 0);
    for (int b = 0; b < 256; b++) begin
      check($sformatf("loop_byte_%0d", b), int'(rx_log[(bv + b) % 512]), b);
    end

    check("valid_ferr_overlap", nboth, 0);
    check("pulse_width", nlong, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
